// File: rtl/memory_pkg.sv
// Shared definitions for the block-oriented data memory and its cache controller.
package memory_pkg;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned BLOCK_WORDS = 4;
   localparam int unsigned ADDR_W      = 6;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      BUSY,
      DONE
   } mem_state_e;

   function automatic int unsigned block_bits(input int unsigned data_w,
                                              input int unsigned block_words);
      return data_w * block_words;
   endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// Loadable down-counter that paces a memory access; holds at zero once expired.
module mem_latency_timer #(
   parameter  int unsigned LATENCY = 5,
   localparam int unsigned CNT_W   = $clog2(LATENCY + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             zero
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/block_data_memory.sv
// Block-wide main memory with programmable access latency and zero-fill after reset.
module block_data_memory #(
   parameter int unsigned DATA_W      = memory_pkg::DATA_W,
   parameter int unsigned BLOCK_WORDS = memory_pkg::BLOCK_WORDS,
   parameter int unsigned ADDR_W      = memory_pkg::ADDR_W,
   parameter int unsigned LATENCY     = 5
) (
   input  logic                                                  clock,
   input  logic                                                  reset,
   input  logic                                                  read,
   input  logic                                                  write,
   input  logic [ADDR_W-1:0]                                     address,
   input  logic [memory_pkg::block_bits(DATA_W, BLOCK_WORDS)-1:0] writedata,
   output logic [memory_pkg::block_bits(DATA_W, BLOCK_WORDS)-1:0] readdata,
   output logic                                                  busywait
);

   import memory_pkg::*;

   localparam int unsigned BLOCK_W = block_bits(DATA_W, BLOCK_WORDS);
   localparam int unsigned DEPTH   = 2 ** ADDR_W;
   localparam int unsigned CNT_W   = $clog2(LATENCY + 1);

   mem_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BLOCK_W-1:0]  data_q, data_d;
   logic [BLOCK_W-1:0]  readdata_q, readdata_d;
   logic                op_write_q, op_write_d;

   logic [BLOCK_W-1:0]  mem_q [DEPTH];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [BLOCK_W-1:0]  mem_wdata;

   logic                req_valid;
   logic                timer_load;
   logic                timer_zero;

   assign req_valid = read ^ write;

   mem_latency_timer #(
      .LATENCY(LATENCY)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load),
      .load_value (CNT_W'(LATENCY - 1)),
      .zero       (timer_zero)
   );

   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      addr_d     = addr_q;
      data_d     = data_q;
      op_write_d = op_write_q;
      readdata_d = readdata_q;
      mem_we     = 1'b0;
      mem_waddr  = addr_q;
      mem_wdata  = data_q;
      timer_load = 1'b0;
      busywait   = 1'b0;

      case (state_q)
         INIT: begin
            busywait   = 1'b1;
            mem_we     = 1'b1;
            mem_waddr  = init_ptr_q;
            mem_wdata  = '0;
            init_ptr_d = init_ptr_q + 1'b1;
            if (&init_ptr_q) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (req_valid) begin
               busywait   = 1'b1;
               timer_load = 1'b1;
               addr_d     = address;
               data_d     = writedata;
               op_write_d = write;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            busywait = 1'b1;
            if (timer_zero) begin
               state_d = DONE;
               if (op_write_q) begin
                  mem_we = 1'b1;
               end else begin
                  readdata_d = mem_q[addr_q];
               end
            end
         end
         // One idle-looking cycle so a requester dropping its request is not re-served.
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= INIT;
         init_ptr_q <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         op_write_q <= 1'b0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         op_write_q <= op_write_d;
         readdata_q <= readdata_d;
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign readdata = readdata_q;

endmodule

// File: tb/tb_block_data_memory.sv
// Randomized bench for block_data_memory: default configuration plus a short-latency sweep instance.
module tb_block_data_memory;

   logic        clock = 1'b0;
   logic        reset;

   logic        read_a, write_a, busywait_a;
   logic [5:0]  address_a;
   logic [31:0] writedata_a, readdata_a;

   logic        read_b, write_b, busywait_b;
   logic [2:0]  address_b;
   logic [15:0] writedata_b, readdata_b;

   logic [31:0] model_a [64];
   logic [15:0] model_b [8];

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clock = ~clock;

   block_data_memory dut_a (
      .clock     (clock),
      .reset     (reset),
      .read      (read_a),
      .write     (write_a),
      .address   (address_a),
      .writedata (writedata_a),
      .readdata  (readdata_a),
      .busywait  (busywait_a)
   );

   block_data_memory #(
      .DATA_W      (8),
      .BLOCK_WORDS (2),
      .ADDR_W      (3),
      .LATENCY     (1)
   ) dut_b (
      .clock     (clock),
      .reset     (reset),
      .read      (read_b),
      .write     (write_b),
      .address   (address_b),
      .writedata (writedata_b),
      .readdata  (readdata_b),
      .busywait  (busywait_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory contents after reset are all zero once INIT has run.
   task automatic clear_models();
      for (int i = 0; i < 64; i++) model_a[i] = '0;
      for (int i = 0; i < 8; i++)  model_b[i] = '0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      clear_models();
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
   endtask

   // Counts cycles with busywait high, starting at the current sample point; stops in the low cycle.
   task automatic count_busy(input bit sel_b, inout int unsigned cnt);
      while ((sel_b ? busywait_b : busywait_a) && cnt < 500) begin
         cnt++;
         @(negedge clock);
         #1;
      end
   endtask

   task automatic access(input bit sel_b, input bit wr, input int unsigned addr,
                         input logic [31:0] data, output int unsigned cnt, output logic [31:0] rd);
      @(negedge clock);
      if (sel_b) begin
         read_b = !wr; write_b = wr; address_b = 3'(addr); writedata_b = data[15:0];
      end else begin
         read_a = !wr; write_a = wr; address_a = 6'(addr); writedata_a = data;
      end
      #1;
      cnt = 0;
      count_busy(sel_b, cnt);
      rd = sel_b ? {16'h0, readdata_b} : readdata_a;
      if (wr) begin
         if (sel_b) model_b[addr] = data[15:0];
         else       model_a[addr] = data;
      end
      read_a = 1'b0; write_a = 1'b0; read_b = 1'b0; write_b = 1'b0;
   endtask

   initial begin
      int unsigned cnt;
      int unsigned hi;
      int unsigned addr;
      logic [31:0] rd;
      logic [31:0] data;

      reset = 1'b1;
      read_a = 1'b0; write_a = 1'b0; address_a = '0; writedata_a = '0;
      read_b = 1'b0; write_b = 1'b0; address_b = '0; writedata_b = '0;

      // Reset and init: read block 0 straight away, stalls through 64 INIT + 6 access cycles.
      do_reset();
      check("reset_readdata", readdata_a, 32'h0);
      access(0, 0, 0, 32'h0, cnt, rd);
      check("init_busy_cycles", cnt, 70);
      check("init_read0", rd, 32'h0);

      // Reset in the middle of INIT restarts the zero-fill from block 0.
      do_reset();
      repeat (20) @(negedge clock);
      do_reset();
      access(0, 0, 0, 32'h0, cnt, rd);
      check("reinit_busy_cycles", cnt, 70);

      // Write then read.
      access(0, 1, 5, 32'h44332211, cnt, rd);
      check("write5_busy", cnt, 6);
      access(0, 0, 5, 32'h0, cnt, rd);
      check("read5_busy", cnt, 6);
      check("read5_data", rd, 32'h44332211);
      access(0, 0, 4, 32'h0, cnt, rd);
      check("read4_data", rd, model_a[4]);

      // Illegal read+write is ignored.
      @(negedge clock);
      read_a = 1'b1; write_a = 1'b1; address_a = 6'd7; writedata_a = $urandom | 32'h1;
      hi = 0;
      repeat (10) begin
         #1;
         if (busywait_a) hi++;
         @(negedge clock);
      end
      check("illegal_busy_cycles", hi, 0);
      read_a = 1'b0; write_a = 1'b0;
      access(0, 0, 7, 32'h0, cnt, rd);
      check("after_illegal_busy", cnt, 6);
      check("after_illegal_read7", rd, 32'h0);

      // Reset during BUSY cycle 3 of a write aborts it.
      access(0, 0, 5, 32'h0, cnt, rd);
      @(negedge clock);
      write_a = 1'b1; address_a = 6'd9; writedata_a = 32'hDEADBEEF;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      write_a = 1'b0;
      clear_models();
      @(posedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      #1;
      check("init_readdata_zero", readdata_a, 32'h0);
      check("init_busywait", busywait_a, 1'b1);
      access(0, 0, 9, 32'h0, cnt, rd);
      check("abort_read9_timeout", cnt < 500, 1'b1);
      check("abort_read9_data", rd, 32'h0);
      access(0, 0, 5, 32'h0, cnt, rd);
      check("abort_read5_data", rd, 32'h0);

      // Held read through DONE with address changed during BUSY.
      access(0, 1, 5, $urandom, cnt, rd);
      access(0, 1, 6, $urandom, cnt, rd);
      @(negedge clock);
      read_a = 1'b1; address_a = 6'd5;
      #1;
      @(negedge clock);
      #1;
      address_a = 6'd6; writedata_a = $urandom;
      cnt = 1;
      count_busy(0, cnt);
      check("held_first_busy", cnt, 6);
      check("held_first_data", readdata_a, model_a[5]);
      @(negedge clock);
      #1;
      check("held_rearm_busy", busywait_a, 1'b1);
      cnt = 0;
      count_busy(0, cnt);
      check("held_second_busy", cnt, 6);
      check("held_second_data", readdata_a, model_a[6]);
      read_a = 1'b0;

      // Random traffic against the array model.
      for (int i = 0; i < 16; i++) begin
         addr = $urandom_range(0, 63);
         data = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            access(0, 1, addr, data, cnt, rd);
            check("rand_write_busy", cnt, 6);
         end else begin
            access(0, 0, addr, 32'h0, cnt, rd);
            check("rand_read_busy", cnt, 6);
            check("rand_read_data", rd, model_a[addr]);
         end
      end

      // Sweep instance: LATENCY=1, 2-word blocks, 8 blocks.
      do_reset();
      access(1, 0, 0, 32'h0, cnt, rd);
      check("sweep_init_busy", cnt, 10);
      check("sweep_init_read0", rd, 32'h0);
      for (int i = 0; i < 8; i++) begin
         data = {16'h0, 8'(i + 8'hA0), 8'($urandom_range(0, 255))};
         access(1, 1, i, data, cnt, rd);
         check("sweep_write_busy", cnt, 2);
      end
      for (int i = 0; i < 8; i++) begin
         access(1, 0, i, 32'h0, cnt, rd);
         check("sweep_read_busy", cnt, 2);
         check("sweep_read_data", rd, {16'h0, model_b[i]});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
